// File: rtl/ita_activation_ctrl.sv
// ita_activation_ctrl: job controller and 2-stage valid/ready pipeline around the N-lane activation datapath
module ita_activation_ctrl #(
  parameter int N       = 16,
  parameter int WI      = 8,
  parameter int CONST_W = 16,
  parameter int EMS     = 8,
  parameter int SHIFT_W = 8,
  parameter int LEN_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [CONST_W-1:0]   one_i,
  input  logic [CONST_W-1:0]   b_i,
  input  logic [CONST_W-1:0]   c_i,
  input  logic [EMS-1:0]       eps_mult_i,
  input  logic [SHIFT_W-1:0]   right_shift_i,
  input  logic [WI-1:0]        add_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [N*WI-1:0]      in_data_i,
  output logic [CONST_W-1:0]   dp_one_o,
  output logic [CONST_W-1:0]   dp_b_o,
  output logic [CONST_W-1:0]   dp_c_o,
  output logic [EMS-1:0]       dp_eps_mult_o,
  output logic [SHIFT_W-1:0]   dp_right_shift_o,
  output logic [WI-1:0]        dp_add_o,
  output logic [N*WI-1:0]      dp_data_o,
  input  logic [N*WI-1:0]      dp_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [N*WI-1:0]      out_data_o,
  output logic                 busy_o,
  output logic                 done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len, cnt_in, cnt_out;
  logic             s1_v, s2_v, s1_adv, s2_adv, in_hs, out_hs;
  logic [N*WI-1:0]  res;
  assign s2_adv      = !s2_v | out_ready_i;
  assign s1_adv      = s1_v & s2_adv;
  assign in_ready_o  = state == RUN & (!s1_v | s1_adv);
  assign in_hs       = in_valid_i & in_ready_o;
  assign out_hs      = s2_v & out_ready_i;
  assign out_valid_o = s2_v;
  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
  // GELU takes the lane result; ReLU and identity act on the stage-1 lane directly
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign res[k*WI+:WI] = mode == 2'd2 ? dp_data_i[k*WI+:WI] :
                           (mode == 2'd1 && dp_data_o[k*WI+WI-1]) ? '0 : dp_data_o[k*WI+:WI];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state            <= IDLE;
      mode             <= '0;
      len              <= '0;
      cnt_in           <= '0;
      cnt_out          <= '0;
      s1_v             <= 1'b0;
      s2_v             <= 1'b0;
      dp_data_o        <= '0;
      out_data_o       <= '0;
      dp_one_o         <= '0;
      dp_b_o           <= '0;
      dp_c_o           <= '0;
      dp_eps_mult_o    <= '0;
      dp_right_shift_o <= '0;
      dp_add_o         <= '0;
    end else begin
      if (in_hs) begin
        dp_data_o <= in_data_i;
        s1_v      <= 1'b1;
        cnt_in    <= cnt_in + LEN_W'(1);
      end else if (s1_adv) s1_v <= 1'b0;
      if (s1_adv) begin
        out_data_o <= res;
        s2_v       <= 1'b1;
      end else if (out_hs) s2_v <= 1'b0;
      if (out_hs) cnt_out <= cnt_out + LEN_W'(1);
      case (state)
        IDLE: if (start_i) begin
          state <= len_i == '0 ? DONE : RUN;
          if (len_i != '0) begin
            mode             <= mode_i;
            len              <= len_i;
            cnt_in           <= '0;
            cnt_out          <= '0;
            dp_one_o         <= one_i;
            dp_b_o           <= b_i;
            dp_c_o           <= c_i;
            dp_eps_mult_o    <= eps_mult_i;
            dp_right_shift_o <= right_shift_i;
            dp_add_o         <= add_i;
          end
        end
        RUN:   if (in_hs && cnt_in + LEN_W'(1) == len) state <= DRAIN;
        DRAIN: if (out_hs && cnt_out + LEN_W'(1) == len) state <= DONE;
        DONE:  state <= IDLE;
      endcase
    end
  end
endmodule
